// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter.
//   - state_e : arbiter state encoding (StIdle / StGrant)
//   - default parameter values and width helpers used by the top level
package shared_reg_arbiter_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_MAX_HOLD = 4;

    // Width of an index into n requesters.
    function automatic int unsigned owner_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach max_hold inclusive.
    function automatic int unsigned hold_width(input int unsigned max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index for this pick
//   found : at least one request is set
//   idx   : first set request scanning ptr, ptr+1, ... with wrap-around
module shared_reg_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters take turns loading one shared
// WIDTH-bit register. Each ownership is capped at MAX_HOLD loads.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   req     : per-requester request, held while the requester wants to write
//   din     : flattened data, slice i = din[i*WIDTH +: WIDTH]
//   grant   : registered one-hot grant (or zero)
//   owner   : registered index of the current / last owner
//   busy    : high while a grant is held
//   q       : shared register contents
//   q_valid : one-cycle pulse after each edge that loaded q
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     din,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid
);

    localparam int unsigned OWNER_W = owner_width(N_REQ);
    localparam int unsigned HOLD_W  = hold_width(MAX_HOLD);

    state_e               state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q_valid_q, q_valid_d;

    logic [OWNER_W-1:0]   next_ptr;
    logic [OWNER_W-1:0]   pick_ptr;
    logic                 pick_found;
    logic [OWNER_W-1:0]   pick_idx;
    logic                 load;
    logic [HOLD_W-1:0]    hold_inc;
    logic                 rearb;

    // Pointer for re-arbitration: the requester after the current owner.
    assign next_ptr = (owner_q == OWNER_W'(N_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);

    // In GRANT the pick only matters on re-arbitration, which uses the new ptr
    // on the same edge; in IDLE the stored ptr applies.
    assign pick_ptr = (state_q == StGrant) ? next_ptr : ptr_q;

    shared_reg_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (OWNER_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign load     = (state_q == StGrant) && req[owner_q];
    assign hold_inc = hold_cnt_q + HOLD_W'(1);
    assign rearb    = (state_q == StGrant) && (!load || (hold_inc == HOLD_W'(MAX_HOLD)));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        q_d        = q_q;
        q_valid_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d           = StGrant;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    hold_cnt_d        = '0;
                end
            end
            StGrant: begin
                if (load) begin
                    q_d        = din[int'(owner_q) * WIDTH +: WIDTH];
                    q_valid_d  = 1'b1;
                    hold_cnt_d = hold_inc;
                end
                if (rearb) begin
                    ptr_d = next_ptr;
                    if (pick_found) begin
                        // Gapless handoff, possibly back to the same owner.
                        grant_d           = '0;
                        grant_d[pick_idx] = 1'b1;
                        owner_d           = pick_idx;
                        hold_cnt_d        = '0;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
        end
    end

    assign grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = (state_q == StGrant);
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

    localparam int N_REQ    = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                   clk;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] din;
    logic [N_REQ-1:0]       grant;
    logic [1:0]             owner;
    logic                   busy;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(
        .N_REQ    (N_REQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .din     (din),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [31:0] d;
        logic [3:0]  eg;
        logic [1:0]  eo;
        logic        eb;
        logic [7:0]  eq;
        logic        ev;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                                 input logic eb, input logic [7:0] eq, input logic ev);
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".owner"}, 32'(owner), 32'(eo));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".q_valid"}, 32'(q_valid), 32'(ev));
    endtask

    // Reference model: spec rules in plain integer arithmetic.
    bit       m_busy;
    int       m_owner, m_ptr, m_loads;
    bit [7:0] m_q;
    bit       m_qv;

    function automatic int rr_first(input bit [3:0] r, input int p);
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit [3:0] r, input bit [31:0] d);
        int w;
        m_qv = 1'b0;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_loads = 0; m_q = '0;
        end else if (!m_busy) begin
            w = rr_first(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_loads = 0;
            end
        end else begin
            if (r[m_owner]) begin
                m_q = d[m_owner*8 +: 8];
                m_qv = 1'b1;
                m_loads++;
            end
            if (!r[m_owner] || m_loads == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % N_REQ;
                w = rr_first(r, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_loads = 0;
                end else begin
                    m_busy = 0;
                end
            end
        end
    endtask

    task automatic set_vec(input int i, input logic rst, input logic [3:0] rq,
                           input logic [31:0] d, input logic [3:0] eg, input logic [1:0] eo,
                           input logic eb, input logic [7:0] eq, input logic ev);
        vecs[i] = '{rst, rq, d, eg, eo, eb, eq, ev};
    endtask

    initial begin
        logic [31:0] dd;
        logic [31:0] ds;
        logic [3:0]  rr;
        bit          rs;
        dd = 32'h1312_1110;
        ds = 32'h13A5_1110;

        // Reset held with all requesting, then first grant goes to 0.
        set_vec(0, 1, 4'hF, dd, 4'b0000, 0, 0, 8'h00, 0);
        set_vec(1, 1, 4'hF, dd, 4'b0000, 0, 0, 8'h00, 0);
        set_vec(2, 0, 4'hF, dd, 4'b0001, 0, 1, 8'h00, 0);
        // All four continuous: four loads each, gapless handoff.
        set_vec(3, 0, 4'hF, dd, 4'b0001, 0, 1, 8'h10, 1);
        set_vec(4, 0, 4'hF, dd, 4'b0001, 0, 1, 8'h10, 1);
        set_vec(5, 0, 4'hF, dd, 4'b0001, 0, 1, 8'h10, 1);
        set_vec(6, 0, 4'hF, dd, 4'b0010, 1, 1, 8'h10, 1);
        set_vec(7, 0, 4'hF, dd, 4'b0010, 1, 1, 8'h11, 1);
        set_vec(8, 0, 4'hF, dd, 4'b0010, 1, 1, 8'h11, 1);
        set_vec(9, 0, 4'hF, dd, 4'b0010, 1, 1, 8'h11, 1);
        set_vec(10, 0, 4'hF, dd, 4'b0100, 2, 1, 8'h11, 1);
        // Reset mid-grant with 1 and 3 pending; ptr back to 0 picks 1.
        set_vec(11, 1, 4'b1010, dd, 4'b0000, 0, 0, 8'h00, 0);
        set_vec(12, 0, 4'b1010, dd, 4'b0010, 1, 1, 8'h00, 0);
        // Early release by owner 1 while 3 waits.
        set_vec(13, 0, 4'b1010, dd, 4'b0010, 1, 1, 8'h11, 1);
        set_vec(14, 0, 4'b1000, dd, 4'b1000, 3, 1, 8'h11, 0);
        set_vec(15, 0, 4'b0000, dd, 4'b0000, 3, 0, 8'h11, 0);
        // Single requester 2: two loads of A5 then drop.
        set_vec(16, 0, 4'b0100, ds, 4'b0100, 2, 1, 8'h11, 0);
        set_vec(17, 0, 4'b0100, ds, 4'b0100, 2, 1, 8'hA5, 1);
        set_vec(18, 0, 4'b0100, ds, 4'b0100, 2, 1, 8'hA5, 1);
        set_vec(19, 0, 4'b0000, ds, 4'b0000, 2, 0, 8'hA5, 0);
        // Lone continuous requester 3 crosses MAX_HOLD without a gap.
        set_vec(20, 0, 4'b1000, dd, 4'b1000, 3, 1, 8'hA5, 0);
        for (int i = 21; i < 27; i++) set_vec(i, 0, 4'b1000, dd, 4'b1000, 3, 1, 8'h13, 1);
        // Requester drops on the edge its grant appears.
        set_vec(27, 0, 4'b0000, dd, 4'b0000, 3, 0, 8'h13, 0);
        set_vec(28, 0, 4'b0001, dd, 4'b0001, 0, 1, 8'h13, 0);
        set_vec(29, 0, 4'b0000, dd, 4'b0000, 0, 0, 8'h13, 0);

        reset = 1'b1;
        req   = '0;
        din   = '0;

        for (int i = 0; i < NV; i++) begin
            reset = vecs[i].rst;
            req   = vecs[i].rq;
            din   = vecs[i].d;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eo, vecs[i].eb,
                          vecs[i].eq, vecs[i].ev);
        end

        // Randomized phase against the reference model.
        reset = 1'b1;
        req   = '0;
        model_step(1'b1, 4'b0, 32'b0);
        @(posedge clk);
        #1;
        rr = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
            end
            rs    = ($urandom_range(0, 63) == 0);
            reset = rs;
            req   = rr;
            din   = $urandom;
            model_step(rs, rr, din);
            @(posedge clk);
            #1;
            check_outputs($sformatf("rand%0d", c), m_busy ? 4'(1 << m_owner) : 4'b0,
                          2'(m_owner), m_busy, m_q, m_qv);
            check($sformatf("rand%0d.onehot", c), 32'($onehot0(grant)), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
